// File: rtl/riscv_prog_loader_pkg.sv
// riscv_loader_pkg: shared state encoding and word geometry for the program loader.
package riscv_loader_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, RELEASE} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W = 2;
endpackage

// File: rtl/riscv_prog_loader_if.sv
// riscv_prog_loader_if: host byte stream, memory write port and core control of the loader.
interface riscv_prog_loader_if #(parameter int ADDR_W = 10) ();
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_last;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_count;
    logic              err_partial;
    logic              err_overflow;

    modport master (
        output start, byte_valid, byte_data, byte_last,
        input  byte_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done,
               word_count, err_partial, err_overflow
    );
    modport slave (
        input  start, byte_valid, byte_data, byte_last,
        output byte_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done,
               word_count, err_partial, err_overflow
    );
endinterface

// File: rtl/riscv_prog_loader_word_pack.sv
// loader_word_pack: little-endian byte-lane assembly of one 32-bit instruction word.
module loader_word_pack
    import riscv_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [7:0]  i_data,
    output logic        o_word_full,
    output logic [31:0] o_word
);
    logic [LANE_W-1:0] r_lane;
    logic [31:0]       r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_load) begin
            r_word[{r_lane, 3'b000} +: 8] <= i_data;
            r_lane                        <= r_lane + 1'b1;
        end
    end

    // High while the next accepted byte completes the word.
    assign o_word_full = (r_lane == LANE_W'(BYTES_PER_WORD - 1));
    assign o_word      = r_word;
endmodule

// File: rtl/riscv_prog_loader.sv
// riscv_prog_loader: streams a byte image into instruction memory while holding the core in reset.
module riscv_prog_loader
    import riscv_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    riscv_prog_loader_if.slave  bus
);
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state, w_next;
    logic              r_last, r_we, r_done, r_core_rst_n, r_err_partial, r_err_overflow;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              w_start, w_hs, w_ovf, w_load, w_clr, w_full;
    logic [31:0]       w_word;

    assign w_start = (r_state == IDLE) & bus.start;
    assign w_hs    = (r_state == LOAD) & bus.byte_valid;
    assign w_ovf   = (r_count == CAP);
    assign w_load  = w_hs & ~w_ovf;
    assign w_clr   = w_start | (r_state == WRITE);

    loader_word_pack u_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_data     (bus.byte_data),
        .o_word_full(w_full),
        .o_word     (w_word)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? LOAD : IDLE;
            LOAD:    if (w_hs) w_next = w_ovf ? (bus.byte_last ? RELEASE : LOAD)
                                              : ((w_full | bus.byte_last) ? WRITE : LOAD);
            WRITE:   w_next = r_last ? RELEASE : LOAD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we           <= 1'b0;
            r_done         <= 1'b0;
            r_core_rst_n   <= 1'b0;
            r_last         <= 1'b0;
            r_addr         <= '0;
            r_count        <= '0;
            r_err_partial  <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_we         <= (w_next == WRITE);
            r_done       <= (w_next == RELEASE);
            // The core runs whenever no session is loading, including the release cycle.
            r_core_rst_n <= (w_next == IDLE) | (w_next == RELEASE);
            if (w_start) begin
                r_last         <= 1'b0;
                r_addr         <= '0;
                r_count        <= '0;
                r_err_partial  <= 1'b0;
                r_err_overflow <= 1'b0;
            end
            if (w_load & bus.byte_last) begin
                r_last <= 1'b1;
                if (!w_full) r_err_partial <= 1'b1;
            end
            if (w_hs & w_ovf) r_err_overflow <= 1'b1;
            if (r_state == WRITE) begin
                r_count <= r_count + 1'b1;
                if (r_addr != '1) r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign bus.byte_ready   = (r_state == LOAD);
    assign bus.busy         = (r_state != IDLE);
    assign bus.mem_we       = r_we;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_wdata    = w_word;
    assign bus.core_rst_n   = r_core_rst_n;
    assign bus.done         = r_done;
    assign bus.word_count   = r_count;
    assign bus.err_partial  = r_err_partial;
    assign bus.err_overflow = r_err_overflow;
endmodule

// File: tb/tb_riscv_prog_loader.sv
// tb_riscv_prog_loader: drives byte images into a 1024-word and a 4-word loader and
// compares memory writes and status against an image-level reference model.
module tb_riscv_prog_loader;
    logic       clk = 1'b0, rst_n = 1'b1;
    logic       sel = 1'b0, h_start = 1'b0, h_valid = 1'b0, h_last = 1'b0;
    logic [7:0] h_data = '0;
    int         n_cmp = 0, n_bad = 0;
    logic [41:0] wq_b[$], wq_s[$];
    logic [7:0]  img[$];
    logic [31:0] wd;

    always #5 clk = ~clk;

    riscv_prog_loader_if #(.ADDR_W(10)) bb ();
    riscv_prog_loader_if #(.ADDR_W(2))  bs ();

    assign bb.start      = h_start & ~sel;
    assign bb.byte_valid = h_valid & ~sel;
    assign bb.byte_data  = h_data;
    assign bb.byte_last  = h_last;
    assign bs.start      = h_start & sel;
    assign bs.byte_valid = h_valid & sel;
    assign bs.byte_data  = h_data;
    assign bs.byte_last  = h_last;

    riscv_prog_loader #(.ADDR_W(10)) u_big   (.clk(clk), .rst_n(rst_n), .bus(bb));
    riscv_prog_loader #(.ADDR_W(2))  u_small (.clk(clk), .rst_n(rst_n), .bus(bs));

    wire        w_ready = sel ? bs.byte_ready   : bb.byte_ready;
    wire        w_done  = sel ? bs.done         : bb.done;
    wire        w_core  = sel ? bs.core_rst_n   : bb.core_rst_n;
    wire        w_busy  = sel ? bs.busy         : bb.busy;
    wire        w_we    = sel ? bs.mem_we       : bb.mem_we;
    wire        w_ep    = sel ? bs.err_partial  : bb.err_partial;
    wire        w_eo    = sel ? bs.err_overflow : bb.err_overflow;
    wire [10:0] w_count = sel ? {8'd0, bs.word_count} : bb.word_count;

    always @(negedge clk) begin
        if (bb.mem_we) wq_b.push_back({bb.mem_addr, bb.mem_wdata});
        if (bs.mem_we) wq_s.push_back({8'd0, bs.mem_addr, bs.mem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_session(input logic s);
        @(negedge clk);
        sel = s;
        wq_b.delete();
        wq_s.delete();
        h_start = 1'b1;
        @(negedge clk);
        h_start = 1'b0;
        chk("busy_after_start", w_busy, 1);
        chk("core_held", w_core, 0);
        chk("count_cleared", w_count, 0);
        chk("errs_cleared", {w_ep, w_eo}, 0);
    endtask

    task automatic send(input logic [7:0] b[$], input int gap, input bit poke, input bit with_last);
        for (int i = 0; i < b.size(); i++) begin
            repeat ($urandom_range(0, gap)) @(negedge clk);
            h_valid = 1'b1;
            h_data  = b[i];
            h_last  = with_last && (i == b.size() - 1);
            h_start = poke;
            for (int t = 0; t < 50 && !w_ready; t++) @(negedge clk);
            if (!w_ready) chk("ready_wait", w_ready, 1);
            @(negedge clk);
            h_valid = 1'b0;
            h_last  = 1'b0;
            h_start = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int t = 0; t < 100 && !w_done; t++) @(negedge clk);
        chk("done_seen", w_done, 1);
        chk("core_run_in_done", w_core, 1);
        @(negedge clk);
        chk("done_one_cycle", w_done, 0);
        chk("idle_after_done", w_busy, 0);
    endtask

    // Expected writes follow directly from the image: 4-byte little-endian chunks,
    // zero-padded, truncated to capacity.
    task automatic check_model(input logic [7:0] b[$], input int cap);
        logic [41:0] q[$];
        logic [31:0] w;
        int len, n;
        len = b.size();
        n   = (len + 3) / 4;
        if (n > cap) n = cap;
        q = sel ? wq_s : wq_b;
        chk("n_writes", q.size(), n);
        chk("other_dut_quiet", sel ? wq_b.size() : wq_s.size(), 0);
        for (int i = 0; i < n && i < q.size(); i++) begin
            w = '0;
            for (int k = 0; k < 4; k++)
                if (4 * i + k < len) w[8 * k +: 8] = b[4 * i + k];
            chk($sformatf("waddr[%0d]", i), q[i][41:32], i);
            chk($sformatf("wdata[%0d]", i), q[i][31:0], w);
        end
        chk("word_count", w_count, n);
        chk("err_partial", w_ep, (len % 4 != 0) && (len < 4 * cap));
        chk("err_overflow", w_eo, len > 4 * cap);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            chk("rst_core", w_core, 0);
            chk("rst_we", w_we, 0);
            chk("rst_done", w_done, 0);
            chk("rst_count", w_count, 0);
            chk("rst_errs", {w_ep, w_eo}, 0);
            chk("rst_busy_ready", {w_busy, w_ready}, 0);
        end
        chk("rst_addr_data", {bb.mem_addr, bb.mem_wdata}, 0);
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("core_release_after_rst", {bb.core_rst_n, bs.core_rst_n}, 2'b11);

        // byte_valid in IDLE must not handshake
        h_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_ready", w_ready, 0);
        chk("idle_no_write", wq_b.size(), 0);
        h_valid = 1'b0;

        img = '{8'h93, 8'h00, 8'hA0, 8'h00};
        start_session(0);
        send(img, 0, 0, 1);
        wait_done();
        check_model(img, 1024);

        img.delete();
        for (int i = 0; i < 16; i++) begin
            wd = (i == 0) ? 32'h00A00093 : (i == 1) ? 32'h01400113 :
                 (i == 9) ? 32'h00020263 : (i == 15) ? 32'h06300613 : $urandom;
            for (int k = 0; k < 4; k++) img.push_back(wd[8 * k +: 8]);
        end
        start_session(0);
        send(img, 3, 0, 1);
        wait_done();
        check_model(img, 1024);

        img = '{8'h13, 8'h01, 8'h40, 8'h01, 8'hAA, 8'hBB};
        start_session(0);
        send(img, 1, 0, 1);
        wait_done();
        check_model(img, 1024);

        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
        start_session(1);
        send(img, 1, 0, 1);
        wait_done();
        check_model(img, 4);

        // reset in the middle of a session discards the partial word
        img = '{8'h11, 8'h22};
        start_session(0);
        send(img, 0, 0, 0);
        chk("busy_mid_load", w_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", w_we, 0);
        chk("mid_rst_core", w_core, 0);
        chk("mid_rst_busy", w_busy, 0);
        chk("mid_rst_count", w_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_no_write", wq_b.size(), 0);
        chk("mid_rst_core_back", w_core, 1);
        img = '{8'h93, 8'h04, 8'h20, 8'h03};
        start_session(0);
        send(img, 0, 0, 1);
        wait_done();
        check_model(img, 1024);

        // start held during LOAD and WRITE is ignored
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        start_session(0);
        send(img, 0, 1, 1);
        wait_done();
        check_model(img, 1024);

        for (int r = 0; r < 8; r++) begin
            img.delete();
            for (int i = $urandom_range(1, 24); i > 0; i--) img.push_back(8'($urandom));
            start_session(1'($urandom_range(0, 1)));
            send(img, 2, 0, 1);
            wait_done();
            check_model(img, sel ? 4 : 1024);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
